// File: rtl/firebird7_in_gate1_tessent_tdr_w3_sel.sv
// IJTAG test data register for the w3 data mux.
// A DATA_WIDTH+1 bit scan chain (select bit on top, data below) feeds a
// shadow update stage that drives the mux select and override data.
// Capture loads the mux output plus the current select for read-back.
module firebird7_in_gate1_tessent_tdr_w3_sel #(
  parameter int                    DATA_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                  ijtag_tck,
  input  logic                  ijtag_reset,
  input  logic                  ijtag_sel,
  input  logic                  ijtag_ce,
  input  logic                  ijtag_se,
  input  logic                  ijtag_ue,
  input  logic                  ijtag_si,
  output logic                  ijtag_so,
  input  logic [DATA_WIDTH-1:0] capture_data_in,
  output logic                  ijtag_select,
  output logic [DATA_WIDTH-1:0] ijtag_data_out
);

  logic [DATA_WIDTH:0]   shift_q, shift_d;
  logic                  select_q, select_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Next-state for chain and shadow; capture beats shift beats update, and
  // the shadow only moves on a pure update so the mux never sees shift ripple.
  always_comb begin
    shift_d  = shift_q;
    select_d = select_q;
    data_d   = data_q;
    if (ijtag_sel) begin
      if (ijtag_ce) begin
        shift_d = {select_q, capture_data_in};
      end else if (ijtag_se) begin
        shift_d = {ijtag_si, shift_q[DATA_WIDTH:1]};
      end else if (ijtag_ue) begin
        select_d = shift_q[DATA_WIDTH];
        data_d   = shift_q[DATA_WIDTH-1:0];
      end
    end
  end

  // State registers; reset returns the mux to functional mode at once.
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      shift_q  <= '0;
      select_q <= 1'b0;
      data_q   <= RESET_DATA;
    end else begin
      shift_q  <= shift_d;
      select_q <= select_d;
      data_q   <= data_d;
    end
  end

  assign ijtag_so       = shift_q[0];
  assign ijtag_select   = select_q;
  assign ijtag_data_out = data_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w3_sel.sv
// Self-checking bench for the w3 select TDR: directed vector table,
// hand-written reset sequences, and random traffic against a queue model.
module tb_firebird7_in_gate1_tessent_tdr_w3_sel;

  localparam int W = 3;

  logic         ijtag_tck = 1'b0;
  logic         ijtag_reset = 1'b1;
  logic         ijtag_sel = 1'b0;
  logic         ijtag_ce = 1'b0;
  logic         ijtag_se = 1'b0;
  logic         ijtag_ue = 1'b0;
  logic         ijtag_si = 1'b0;
  logic         ijtag_so;
  logic [W-1:0] capture_data_in = '0;
  logic         ijtag_select;
  logic [W-1:0] ijtag_data_out;

  int checks_total = 0;
  int checks_passed = 0;

  firebird7_in_gate1_tessent_tdr_w3_sel #(.DATA_WIDTH(W), .RESET_DATA(3'b000)) dut (
    .ijtag_tck       (ijtag_tck),
    .ijtag_reset     (ijtag_reset),
    .ijtag_sel       (ijtag_sel),
    .ijtag_ce        (ijtag_ce),
    .ijtag_se        (ijtag_se),
    .ijtag_ue        (ijtag_ue),
    .ijtag_si        (ijtag_si),
    .ijtag_so        (ijtag_so),
    .capture_data_in (capture_data_in),
    .ijtag_select    (ijtag_select),
    .ijtag_data_out  (ijtag_data_out)
  );

  // Free-running test clock.
  always #5 ijtag_tck = ~ijtag_tck;

  typedef struct {
    string        name;
    logic         sel, ce, se, ue, si;
    logic [W-1:0] cap;
    logic         exp_so;
    logic         exp_select;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  // Reference model: chain as a bit queue, element 0 is the scan-out end.
  bit     m_chain[$];
  bit     m_select;
  int     m_data;

  function automatic void add_vec(string name, logic sel, logic ce, logic se, logic ue,
                                  logic si, logic [W-1:0] cap, logic eso,
                                  logic esel, logic [W-1:0] edata);
    vec_t v;
    v.name = name; v.sel = sel; v.ce = ce; v.se = se; v.ue = ue; v.si = si;
    v.cap = cap; v.exp_so = eso; v.exp_select = esel; v.exp_data = edata;
    vecs.push_back(v);
  endfunction

  function automatic void model_reset();
    m_chain.delete();
    for (int i = 0; i <= W; i++) m_chain.push_back(1'b0);
    m_select = 1'b0;
    m_data   = 0;
  endfunction

  function automatic void model_edge(bit sel, bit ce, bit se, bit ue, bit si, int cap);
    if (!sel) return;
    if (ce) begin
      m_chain.delete();
      for (int i = 0; i < W; i++) m_chain.push_back(bit'((cap >> i) & 1));
      m_chain.push_back(m_select);
    end else if (se) begin
      void'(m_chain.pop_front());
      m_chain.push_back(si);
    end else if (ue) begin
      m_select = m_chain[W];
      m_data = 0;
      for (int i = 0; i < W; i++) m_data += int'(m_chain[i]) * (1 << i);
    end
  endfunction

  task automatic checkOutput(string name, logic eso, logic esel, logic [W-1:0] edata);
    checks_total++;
    if (ijtag_so === eso && ijtag_select === esel && ijtag_data_out === edata) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got so=%b select=%b data=%b, expected so=%b select=%b data=%b",
               name, ijtag_so, ijtag_select, ijtag_data_out, eso, esel, edata);
    end
  endtask

  task automatic applyStimulus(logic sel, logic ce, logic se, logic ue, logic si,
                               logic [W-1:0] cap);
    ijtag_sel = sel; ijtag_ce = ce; ijtag_se = se; ijtag_ue = ue;
    ijtag_si = si; capture_data_in = cap;
    @(posedge ijtag_tck);
    #1;
  endtask

  task automatic idle();
    ijtag_sel = 1'b0; ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0;
  endtask

  task automatic pulse_reset();
    ijtag_reset = 1'b1;
    #1;
  endtask

  initial begin
    // Shift 1,0,1,1 then update; capture 110 and shift out; sel=0 freeze;
    // ce+se priority; se+ue priority.
    add_vec("shift1",      1,0,1,0,1, 3'b000, 0, 0, 3'b000);
    add_vec("shift2",      1,0,1,0,0, 3'b000, 0, 0, 3'b000);
    add_vec("shift3",      1,0,1,0,1, 3'b000, 0, 0, 3'b000);
    add_vec("shift4",      1,0,1,0,1, 3'b000, 1, 0, 3'b000);
    add_vec("update1101",  1,0,0,1,0, 3'b000, 1, 1, 3'b101);
    add_vec("capture110",  1,1,0,0,0, 3'b110, 0, 1, 3'b101);
    add_vec("shiftout1",   1,0,1,0,0, 3'b000, 1, 1, 3'b101);
    add_vec("shiftout2",   1,0,1,0,0, 3'b000, 1, 1, 3'b101);
    add_vec("shiftout3",   1,0,1,0,0, 3'b000, 1, 1, 3'b101);
    add_vec("shiftout4",   1,0,1,0,0, 3'b000, 0, 1, 3'b101);
    add_vec("unsel_all",   0,1,1,1,1, 3'b111, 0, 1, 3'b101);
    add_vec("unsel_se",    0,0,1,0,1, 3'b111, 0, 1, 3'b101);
    add_vec("unsel_ue",    0,0,0,1,1, 3'b111, 0, 1, 3'b101);
    add_vec("unsel_ce",    0,1,0,0,1, 3'b111, 0, 1, 3'b101);
    add_vec("unsel_seue",  0,0,1,1,0, 3'b111, 0, 1, 3'b101);
    add_vec("unsel_ceue",  0,1,0,1,1, 3'b010, 0, 1, 3'b101);
    add_vec("unsel_cese",  0,1,1,0,1, 3'b111, 0, 1, 3'b101);
    add_vec("unsel_all2",  0,1,1,1,0, 3'b111, 0, 1, 3'b101);
    add_vec("update0000",  1,0,0,1,0, 3'b000, 0, 0, 3'b000);
    add_vec("ce_beats_se", 1,1,1,0,1, 3'b011, 1, 0, 3'b000);
    add_vec("update0011",  1,0,0,1,0, 3'b000, 1, 0, 3'b011);
    add_vec("se_beats_ue", 1,0,1,1,0, 3'b000, 1, 0, 3'b011);
    add_vec("hold",        1,0,0,0,1, 3'b111, 1, 0, 3'b011);

    // Reset state.
    #1;
    checkOutput("reset_state", 1'b0, 1'b0, 3'b000);
    @(posedge ijtag_tck); #1;
    ijtag_reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel, vecs[i].ce, vecs[i].se, vecs[i].ue, vecs[i].si, vecs[i].cap);
      checkOutput(vecs[i].name, vecs[i].exp_so, vecs[i].exp_select, vecs[i].exp_data);
    end

    // Asynchronous reset from a non-zero state takes effect without a clock.
    idle();
    pulse_reset();
    checkOutput("async_reset", 1'b0, 1'b0, 3'b000);
    @(posedge ijtag_tck); #1;
    ijtag_reset = 1'b0;

    // Reset mid-shift discards the partial chain.
    applyStimulus(1, 0, 1, 0, 1, 3'b000);
    applyStimulus(1, 0, 1, 0, 1, 3'b000);
    idle();
    pulse_reset();
    checkOutput("midshift_reset", 1'b0, 1'b0, 3'b000);
    ijtag_reset = 1'b0;
    applyStimulus(1, 0, 0, 1, 0, 3'b000);
    checkOutput("update_after_reset", 1'b0, 1'b0, 3'b000);

    // Full re-shift of 1010 (bit0 first) then update.
    applyStimulus(1, 0, 1, 0, 0, 3'b000);
    applyStimulus(1, 0, 1, 0, 1, 3'b000);
    applyStimulus(1, 0, 1, 0, 0, 3'b000);
    applyStimulus(1, 0, 1, 0, 1, 3'b000);
    checkOutput("reshift_1010", 1'b0, 1'b0, 3'b000);
    applyStimulus(1, 0, 0, 1, 0, 3'b000);
    checkOutput("update_1010", 1'b0, 1'b1, 3'b010);

    // Random traffic against the queue model, with occasional resets.
    idle();
    pulse_reset();
    model_reset();
    ijtag_reset = 1'b0;
    for (int n = 0; n < 400; n++) begin
      bit sel, ce, se, ue, si, rst;
      int cap;
      rst = ($urandom_range(0, 39) == 0);
      sel = ($urandom_range(0, 4) != 0);
      ce  = ($urandom_range(0, 5) == 0);
      se  = $urandom_range(0, 1);
      ue  = ($urandom_range(0, 2) == 0);
      si  = $urandom_range(0, 1);
      cap = $urandom_range(0, 7);
      if (rst) begin
        ijtag_reset = 1'b1;
        #1;
        model_reset();
        checkOutput("rand_async_reset", m_chain[0], m_select, W'(m_data));
      end else begin
        ijtag_reset = 1'b0;
      end
      applyStimulus(sel, ce, se, ue, si, W'(cap));
      if (rst) model_reset();
      else model_edge(sel, ce, se, ue, si, cap);
      checkOutput("rand", m_chain[0], m_select, W'(m_data));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
